// File: rtl/display_scan_pkg.sv
// display_pkg: shared types and width helpers for the display scan controller.
//
// Contents:
//   slot_state_t     - slot FSM state (SLOT_GUARD: all digits off, SLOT_ON: digit lit)
//   DEFAULT_*        - default parameter values for an 8-digit, 100 MHz display
//   CNT_W / IDX_W    - counter widths for the default PRESCALE / N_DIGITS
//   width_for()      - width helper for modules built with non-default parameters
package display_pkg;

  typedef enum logic {
    SLOT_GUARD = 1'b0,
    SLOT_ON    = 1'b1
  } slot_state_t;

  localparam int DEFAULT_N_DIGITS = 8;
  localparam int DEFAULT_PRESCALE = 100000;
  localparam int DEFAULT_GUARD    = 1000;

  localparam int CNT_W = $clog2(DEFAULT_PRESCALE);
  localparam int IDX_W = $clog2(DEFAULT_N_DIGITS);

  // Same as $clog2, but never returns 0, so a counter for a single-valued
  // range (e.g. a one-digit display) still gets a legal one-bit vector.
  function automatic int width_for(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: bundles the host-side value/load controls and the
// display-side outputs of the scan controller.
//
// Signals:
//   value       4*N_DIGITS  value to display, nibble i -> digit i (digit 0 rightmost)
//   load        1           single-cycle strobe capturing value
//   lzb_en      1           leading-zero blanking enable
//   digitselect N_DIGITS    active-low digit enables, at most one low
//   nibble      4           hex nibble for the selected digit
//   blank       1           forces the downstream decoder off
//   frame_done  1           one-cycle pulse after each frame wrap
//
// Modports:
//   master - the parent / host driving value, load and lzb_en
//   slave  - the display_scan controller
interface display_scan_if
  import display_pkg::*;
#(
  parameter int N_DIGITS = DEFAULT_N_DIGITS
) ();

  logic [4*N_DIGITS-1:0] value;
  logic                  load;
  logic                  lzb_en;
  logic [N_DIGITS-1:0]   digitselect;
  logic [3:0]            nibble;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output value, load, lzb_en,
    input  digitselect, nibble, blank, frame_done
  );

  modport slave (
    input  value, load, lzb_en,
    output digitselect, nibble, blank, frame_done
  );

endinterface

// File: rtl/display_scan_slot_timer.sv
// slot_timer: digit-slot timebase for the display scan controller.
//
// cnt runs 0..PRESCALE-1 inside each digit slot; idx steps through the
// digits once per slot. The slot FSM sits in SLOT_GUARD for the first GUARD
// cycles of every slot and in SLOT_ON for the rest.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   idx           current digit index (registered)
//   state         current slot state (registered)
//   slot_wrap     high in the last cycle of a slot
//   frame_wrap    high in the last cycle of the last digit's slot
module slot_timer
  import display_pkg::*;
#(
  parameter int N_DIGITS  = DEFAULT_N_DIGITS,
  parameter int PRESCALE  = DEFAULT_PRESCALE,
  parameter int GUARD     = DEFAULT_GUARD,
  localparam int CW       = width_for(PRESCALE),
  localparam int IW       = width_for(N_DIGITS)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [IW-1:0] idx,
  output slot_state_t   state,
  output logic          slot_wrap,
  output logic          frame_wrap
);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  // Without a guard interval the FSM never leaves SLOT_ON, so it must
  // also come out of reset there.
  localparam slot_state_t STATE_RESET = (GUARD == 0) ? SLOT_ON : SLOT_GUARD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  slot_state_t   state_q, state_d;

  // Next-state logic for the slot counter, digit index and slot FSM.
  // The FSM looks at the next count so that its state always matches
  // the count it is registered alongside.
  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);

    cnt_d = slot_wrap ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    state_d = state_q;
    case (state_q)
      SLOT_GUARD: begin
        if (cnt_d == CNT_GUARD) begin
          state_d = SLOT_ON;
        end
      end
      SLOT_ON: begin
        if (slot_wrap && (GUARD != 0)) begin
          state_d = SLOT_GUARD;
        end
      end
      default: state_d = STATE_RESET;
    endcase
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= STATE_RESET;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign idx   = idx_q;
  assign state = state_q;

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexing scan controller for an N_DIGITS-digit
// seven-segment display. Feeds an external hex-to-seven-segment decoder.
//
// A load stores value in a pending register; the pending value is moved
// into the displayed shadow copy only at a frame wrap, so a frame never
// mixes old and new digits. Each digit slot starts with an all-off guard
// interval against ghosting, and leading zeros may optionally be blanked.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   bus (slave)   value/load/lzb_en in; digitselect/nibble/blank/frame_done out
//
// All outputs are registered and trail the internal timebase by one cycle.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS = DEFAULT_N_DIGITS,
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int GUARD    = DEFAULT_GUARD
) (
  input  logic           clk,
  input  logic           reset_n,
  display_scan_if.slave  bus
);

  localparam int IW = width_for(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;

  logic [IW-1:0] idx;
  slot_state_t   state;
  logic          unused_slot_wrap;
  logic          frame_wrap;

  slot_timer #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_slot_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .idx        (idx),
    .state      (state),
    .slot_wrap  (unused_slot_wrap),
    .frame_wrap (frame_wrap)
  );

  logic [VW-1:0]       pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [VW-1:0]       shadow_q, shadow_d;
  logic [N_DIGITS-1:0] digitselect_q, digitselect_d;
  logic [3:0]          nibble_q, nibble_d;
  logic                blank_q, blank_d;
  logic                frame_done_q, frame_done_d;

  logic [VW-1:0]       upper;
  logic                digit_blank;

  // Capture path. The last load before a frame wrap wins; a load landing
  // exactly on the wrap bypasses pending and is displayed in the very
  // next frame, leaving nothing pending behind it.
  always_comb begin
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    shadow_d  = shadow_q;

    if (bus.load) begin
      pending_d = bus.value;
      pend_v_d  = 1'b1;
    end

    if (frame_wrap) begin
      if (bus.load) begin
        shadow_d = bus.value;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pending_q;
        pend_v_d = 1'b0;
      end
    end
  end

  // Digit selection and blanking. Shifting the shadow right by the current
  // digit leaves exactly nibbles idx..N_DIGITS-1, so the digit is a leading
  // zero when that remainder is zero. Digit 0 is always shown so that a
  // zero value still displays "0".
  always_comb begin
    upper       = shadow_q >> {idx, 2'b00};
    digit_blank = bus.lzb_en && (idx != '0) && (upper == '0);

    nibble_d      = upper[3:0];
    digitselect_d = '1;
    blank_d       = 1'b1;
    if ((state == SLOT_ON) && !digit_blank) begin
      digitselect_d[idx] = 1'b0;
      blank_d            = 1'b0;
    end

    frame_done_d = frame_wrap;
  end

  // Capture and output registers. Reset discards any pending load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      pend_v_q      <= 1'b0;
      shadow_q      <= '0;
      digitselect_q <= '1;
      nibble_q      <= 4'h0;
      blank_q       <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pend_v_q      <= pend_v_d;
      shadow_q      <= shadow_d;
      digitselect_q <= digitselect_d;
      nibble_q      <= nibble_d;
      blank_q       <= blank_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.digitselect = digitselect_q;
  assign bus.nibble      = nibble_q;
  assign bus.blank       = blank_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed self-checking bench for display_scan with
// PRESCALE=8, GUARD=2, N_DIGITS=8 (one slot = 8 cycles, one frame = 64).
//
// cyc counts rising edges since the last reset release; outputs are sampled
// 1 time unit after each edge. The output seen at cyc c reflects internal
// cycle c-1, so digit d of frame F is lit for cyc 64F+8d+3 .. 64F+8d+8.
module tb_display_scan;

  localparam int N_DIGITS = 8;
  localparam int PRESCALE = 8;
  localparam int GUARD    = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Expected startup profile for cyc 0..11 after a reset release.
  logic [7:0] prof_ds    [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE,
                                  8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
  logic       prof_blank [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [7:0] sel_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hDF, 8'hBF, 8'h7F};
  // Digits 0..7 of 32'h1234_ABCD.
  logic [3:0] scan_nib [8] = '{4'hD, 4'hC, 4'hB, 4'hA,
                               4'h4, 4'h3, 4'h2, 4'h1};
  // Digits 4..7 of 32'h1234_ABCD, still on screen after the FFFF_FFFF load.
  logic [3:0] old_nib  [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

  display_scan_if #(.N_DIGITS(N_DIGITS)) bus ();

  display_scan #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic apply_stimulus(input logic [31:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [7:0] e_ds,
                              input logic [3:0] e_nib, input logic e_blank,
                              input logic e_fd);
    vectors++;
    assert (bus.digitselect === e_ds) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d digitselect: observed %h expected %h", tag, cyc, bus.digitselect, e_ds);
    end
    vectors++;
    assert (bus.nibble === e_nib) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d nibble: observed %h expected %h", tag, cyc, bus.nibble, e_nib);
    end
    vectors++;
    assert (bus.blank === e_blank) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d blank: observed %b expected %b", tag, cyc, bus.blank, e_blank);
    end
    vectors++;
    assert (bus.frame_done === e_fd) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc %0d frame_done: observed %b expected %b", tag, cyc, bus.frame_done, e_fd);
    end
  endtask

  task automatic check_startup(input string tag);
    for (int k = 0; k < 12; k++) begin
      run_to(k);
      check_output(tag, prof_ds[k], 4'h0, prof_blank[k], 1'b0);
    end
  endtask

  initial begin
    bus.value  = '0;
    bus.load   = 1'b0;
    bus.lzb_en = 1'b0;

    // Reset and first slot.
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_held", 8'hFF, 4'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    cyc     = 0;
    check_startup("startup");

    // Load mid-frame; it appears only after the next frame wrap.
    run_to(20);
    apply_stimulus(32'h1234_ABCD);
    run_to(63);
    check_output("pre_wrap", 8'h7F, 4'h0, 1'b0, 1'b0);
    run_to(64);
    check_output("frame_done_1", 8'h7F, 4'h0, 1'b0, 1'b1);
    for (int d = 0; d < 8; d++) begin
      run_to(64 + 8*d + 1);
      check_output("scan_guard", 8'hFF, scan_nib[d], 1'b1, 1'b0);
      run_to(64 + 8*d + 4);
      check_output("scan_on", sel_tab[d], scan_nib[d], 1'b0, 1'b0);
    end
    run_to(127);
    check_output("frame_done_low", 8'h7F, 4'h1, 1'b0, 1'b0);
    run_to(128);
    check_output("frame_done_2", 8'h7F, 4'h1, 1'b0, 1'b1);

    // Tear-free update: load while digit 3 of frame 2 is scanning.
    run_to(153);
    apply_stimulus(32'hFFFF_FFFF);
    for (int d = 4; d < 8; d++) begin
      run_to(128 + 8*d + 4);
      check_output("tear_free_old", sel_tab[d], old_nib[d-4], 1'b0, 1'b0);
    end
    run_to(192);
    check_output("tear_free_wrap", 8'h7F, 4'h1, 1'b0, 1'b1);
    run_to(193);
    check_output("tear_free_first", 8'hFF, 4'hF, 1'b1, 1'b0);
    run_to(196);
    check_output("tear_free_d0", 8'hFE, 4'hF, 1'b0, 1'b0);

    // Load on the frame wrap, then a second load of zero one cycle later.
    run_to(255);
    apply_stimulus(32'h8765_4321);
    apply_stimulus(32'h0000_0000);
    run_to(260);
    check_output("wrap_load_d0", 8'hFE, 4'h1, 1'b0, 1'b0);
    run_to(284);
    check_output("wrap_load_d3", 8'hF7, 4'h4, 1'b0, 1'b0);
    run_to(316);
    check_output("wrap_load_d7", 8'h7F, 4'h8, 1'b0, 1'b0);
    run_to(320);
    check_output("wrap_load_fd", 8'h7F, 4'h8, 1'b0, 1'b1);
    run_to(324);
    check_output("second_load_d0", 8'hFE, 4'h0, 1'b0, 1'b0);

    // Leading-zero blanking with 0000_0050, then with 0.
    run_to(330);
    apply_stimulus(32'h0000_0050);
    run_to(380);
    check_output("no_lzb_d7", 8'h7F, 4'h0, 1'b0, 1'b0);
    run_to(382);
    bus.lzb_en = 1'b1;
    run_to(388);
    check_output("lzb_d0", 8'hFE, 4'h0, 1'b0, 1'b0);
    run_to(396);
    check_output("lzb_d1", 8'hFD, 4'h5, 1'b0, 1'b0);
    run_to(400);
    apply_stimulus(32'h0000_0000);
    run_to(404);
    check_output("lzb_d2", 8'hFF, 4'h0, 1'b1, 1'b0);
    run_to(444);
    check_output("lzb_d7", 8'hFF, 4'h0, 1'b1, 1'b0);
    run_to(452);
    check_output("lzb_zero_d0", 8'hFE, 4'h0, 1'b0, 1'b0);
    run_to(460);
    check_output("lzb_zero_d1", 8'hFF, 4'h0, 1'b1, 1'b0);
    run_to(469);
    check_output("lzb_toggle_before", 8'hFF, 4'h0, 1'b1, 1'b0);
    bus.lzb_en = 1'b0;
    run_to(470);
    check_output("lzb_toggle_after", 8'hFB, 4'h0, 1'b0, 1'b0);

    // Reset at digit 5 with a load pending.
    run_to(480);
    apply_stimulus(32'h0060_0000);
    run_to(520);
    apply_stimulus(32'hDEAD_BEEF);
    run_to(557);
    check_output("pre_reset_d5", 8'hDF, 4'h6, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check_output("reset_async", 8'hFF, 4'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hold", 8'hFF, 4'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    cyc     = 0;
    check_startup("restart");
    run_to(64);
    check_output("restart_fd", 8'h7F, 4'h0, 1'b0, 1'b1);
    run_to(65);
    check_output("restart_no_pending", 8'hFF, 4'h0, 1'b1, 1'b0);
    run_to(108);
    check_output("restart_d5", 8'hDF, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
